// File: rtl/gpmc_csr_pkg.sv
// gpmc_csr_pkg: register index map shared by the GPMC CSR bank and its bench.
package gpmc_csr_pkg;

    localparam int IDX_ID      = 0;
    localparam int IDX_SCRATCH = 1;
    localparam int IDX_STICKY  = 2;
    localparam int IDX_MASK    = 3;
    localparam int IDX_PULSE   = 4;

    function automatic int idx_ctrl0();
        return 5;
    endfunction

    function automatic int idx_status0(input int n_ctrl);
        return idx_ctrl0() + n_ctrl;
    endfunction

    function automatic int idx_cnt0(input int n_ctrl, input int n_status);
        return idx_status0(n_ctrl) + n_status;
    endfunction

    function automatic int nregs(input int n_ctrl, input int n_status, input int n_events);
        return idx_cnt0(n_ctrl, n_status) + n_events;
    endfunction

endpackage

// File: rtl/gpmc_csr_bank_if.sv
// gpmc_csr_bank_if: GPMC host-side register access bus.
interface gpmc_csr_bank_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    logic                  address_valid;
    logic [ADDR_WIDTH-1:0] address;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  hit;

    modport master(output address_valid, address, wr_en, wr_data, input rd_data, hit);
    modport slave(input address_valid, address, wr_en, wr_data, output rd_data, hit);
endinterface

// File: rtl/sat_event_counter.sv
// sat_event_counter: saturating event counter; a clear in the same cycle as an event yields 1.
module sat_event_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] count
);
    always_ff @(posedge clk) begin
        if (reset) count <= '0;
        else if (clr) count <= CNT_WIDTH'(inc);
        else if (inc && !(&count)) count <= count + 1'b1;
    end
endmodule

// File: rtl/gpmc_csr_bank.sv
// gpmc_csr_bank: generic CSR bank (ID, scratch, sticky/mask irq, pulses, ctrl, status, counters).
module gpmc_csr_bank
    import gpmc_csr_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    DATA_WIDTH   = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 'h0040,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE     = 'hC10D,
    parameter logic [DATA_WIDTH-1:0] SCRATCH_INIT = 'h1234,
    parameter int                    N_CTRL       = 4,
    parameter int                    N_STATUS     = 4,
    parameter int                    N_EVENTS     = 8,
    parameter int                    CNT_WIDTH    = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    gpmc_csr_bank_if.slave                 bus,
    input  logic [N_EVENTS-1:0]            events_in,
    input  logic [N_STATUS*DATA_WIDTH-1:0] status_in,
    output logic [N_CTRL*DATA_WIDTH-1:0]   ctrl_out,
    output logic [DATA_WIDTH-1:0]          pulse_out,
    output logic                           irq
);
    localparam int NR = nregs(N_CTRL, N_STATUS, N_EVENTS);
    localparam int C0 = idx_ctrl0();
    localparam int S0 = idx_status0(N_CTRL);
    localparam int K0 = idx_cnt0(N_CTRL, N_STATUS);

    logic [ADDR_WIDTH-2:0]                 idx;
    int unsigned                           ri;
    logic                                  in_range, we, rd_hit;
    logic [DATA_WIDTH-1:0]                 scratch, rdat;
    logic [N_EVENTS-1:0]                   sticky, mask;
    logic [N_CTRL-1:0][DATA_WIDTH-1:0]     ctrl;
    logic [N_EVENTS-1:0][CNT_WIDTH-1:0]    cnt;

    // Halfword index; address[0] only matters for the lower-bound compare.
    assign idx      = bus.address[ADDR_WIDTH-1:1] - BASE_ADDR[ADDR_WIDTH-1:1];
    assign ri       = 32'(idx);
    assign in_range = (bus.address >= BASE_ADDR) && (ri < NR);
    assign we       = bus.wr_en && in_range;
    assign rd_hit   = bus.address_valid && in_range;
    assign ctrl_out = ctrl;

    for (genvar g = 0; g < N_EVENTS; g++) begin : g_cnt
        sat_event_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
            .clk  (clk),
            .reset(reset),
            .inc  (events_in[g]),
            .clr  (we && ri == K0 + g),
            .count(cnt[g])
        );
    end

    always_comb begin
        rdat = '0;
        if (ri == IDX_ID) rdat = ID_VALUE;
        if (ri == IDX_SCRATCH) rdat = scratch;
        if (ri == IDX_STICKY) rdat = DATA_WIDTH'(sticky);
        if (ri == IDX_MASK) rdat = DATA_WIDTH'(mask);
        for (int i = 0; i < N_CTRL; i++) if (ri == C0 + i) rdat = ctrl[i];
        for (int i = 0; i < N_STATUS; i++) if (ri == S0 + i) rdat = status_in[i*DATA_WIDTH +: DATA_WIDTH];
        for (int i = 0; i < N_EVENTS; i++) if (ri == K0 + i) rdat = DATA_WIDTH'(cnt[i]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rd_data <= '0;
            bus.hit     <= 1'b0;
            pulse_out   <= '0;
            irq         <= 1'b0;
            scratch     <= SCRATCH_INIT;
            sticky      <= '0;
            mask        <= '0;
            ctrl        <= '0;
        end else begin
            bus.rd_data <= rd_hit ? rdat : '0;
            bus.hit     <= rd_hit;
            pulse_out   <= (we && ri == IDX_PULSE) ? bus.wr_data : '0;
            irq         <= |(sticky & mask);
            if (we && ri == IDX_SCRATCH) scratch <= bus.wr_data;
            if (we && ri == IDX_MASK) mask <= bus.wr_data[N_EVENTS-1:0];
            // Set wins over a simultaneous write-1-to-clear.
            sticky <= (sticky & ~((we && ri == IDX_STICKY) ? bus.wr_data[N_EVENTS-1:0] : '0)) | events_in;
            for (int i = 0; i < N_CTRL; i++) if (we && ri == C0 + i) ctrl[i] <= bus.wr_data;
        end
    end
endmodule

// File: tb/tb_gpmc_csr_bank.sv
// tb_gpmc_csr_bank: directed self-checking bench for gpmc_csr_bank (CNT_WIDTH = 4).
module tb_gpmc_csr_bank;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  events_in;
    logic [63:0] status_in;
    logic [63:0] ctrl_out;
    logic [15:0] pulse_out;
    logic        irq;
    int          n_chk = 0;
    int          n_fail = 0;

    gpmc_csr_bank_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();

    gpmc_csr_bank #(.CNT_WIDTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .events_in(events_in),
        .status_in(status_in),
        .ctrl_out (ctrl_out),
        .pulse_out(pulse_out),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [15:0] a, input logic [15:0] exp, input logic exp_hit, input string tag);
        bus.address = a;
        bus.address_valid = 1'b1;
        tick();
        bus.address_valid = 1'b0;
        check({tag, " data"}, 32'(bus.rd_data), 32'(exp));
        check({tag, " hit"}, 32'(bus.hit), 32'(exp_hit));
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        bus.address = a;
        bus.wr_data = d;
        bus.wr_en = 1'b1;
        tick();
        bus.wr_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        events_in = '0;
        status_in = '0;
        bus.address_valid = 1'b0;
        bus.address = '0;
        bus.wr_en = 1'b0;
        bus.wr_data = '0;
        tick();
        tick();
        check("reset rd_data", 32'(bus.rd_data), 0);
        check("reset hit", 32'(bus.hit), 0);
        check("reset irq", 32'(irq), 0);
        check("reset pulse", 32'(pulse_out), 0);
        check("reset ctrl", ctrl_out[31:0], 0);
        reset = 1'b0;

        rd(16'h0040, 16'hC10D, 1'b1, "id");
        rd(16'h0042, 16'h1234, 1'b1, "scratch");
        rd(16'h004E, 16'h0000, 1'b1, "ctrl2");

        wr(16'h004A, 16'hBEEF);
        check("ctrl0 out", 32'(ctrl_out[15:0]), 32'hBEEF);
        rd(16'h004A, 16'hBEEF, 1'b1, "ctrl0 rd");
        rd(16'h003E, 16'h0000, 1'b0, "below");
        rd(16'h006A, 16'h0000, 1'b0, "above");
        rd(16'h0069, 16'h0000, 1'b1, "cnt7 odd");

        status_in[31:16] = 16'h5A5A;
        rd(16'h0054, 16'h5A5A, 1'b1, "status1");
        wr(16'h0054, 16'h1111);
        rd(16'h0054, 16'h5A5A, 1'b1, "status ro");
        wr(16'h0040, 16'h0000);
        rd(16'h0040, 16'hC10D, 1'b1, "id ro");

        events_in = 8'h08;
        tick();
        events_in = 8'h00;
        tick();
        events_in = 8'h08;
        tick();
        events_in = 8'h00;
        check("irq masked", 32'(irq), 0);
        wr(16'h0046, 16'h0008);
        tick();
        check("irq set", 32'(irq), 1);
        rd(16'h0044, 16'h0008, 1'b1, "sticky");
        rd(16'h0060, 16'h0002, 1'b1, "cnt3 two");
        rd(16'h0046, 16'h0008, 1'b1, "mask");

        events_in = 8'h08;
        wr(16'h0044, 16'h0008);
        events_in = 8'h00;
        rd(16'h0044, 16'h0008, 1'b1, "sticky set wins");
        rd(16'h0060, 16'h0003, 1'b1, "cnt3 three");
        check("irq held", 32'(irq), 1);

        wr(16'h0044, 16'h0008);
        check("irq lag", 32'(irq), 1);
        tick();
        check("irq clear", 32'(irq), 0);
        rd(16'h0044, 16'h0000, 1'b1, "sticky cleared");

        events_in = 8'h01;
        repeat (20) tick();
        events_in = 8'h00;
        rd(16'h005A, 16'h000F, 1'b1, "cnt0 sat");
        events_in = 8'h01;
        wr(16'h005A, 16'h0000);
        events_in = 8'h00;
        rd(16'h005A, 16'h0001, 1'b1, "cnt0 clr+inc");
        wr(16'h005A, 16'h0000);
        rd(16'h005A, 16'h0000, 1'b1, "cnt0 clr");

        wr(16'h0048, 16'h00A5);
        check("pulse on", 32'(pulse_out), 32'h00A5);
        tick();
        check("pulse off", 32'(pulse_out), 0);
        rd(16'h0048, 16'h0000, 1'b1, "pulse rd");
        bus.address = 16'h0048;
        bus.wr_en = 1'b1;
        bus.wr_data = 16'h0001;
        tick();
        check("pulse b2b 1", 32'(pulse_out), 1);
        bus.wr_data = 16'h0002;
        tick();
        check("pulse b2b 2", 32'(pulse_out), 2);
        bus.wr_en = 1'b0;
        tick();
        check("pulse b2b end", 32'(pulse_out), 0);

        events_in = 8'h08;
        tick();
        events_in = 8'h00;
        tick();
        check("irq pre-reset", 32'(irq), 1);
        bus.address = 16'h0042;
        bus.wr_data = 16'hAAAA;
        bus.wr_en = 1'b1;
        bus.address_valid = 1'b1;
        events_in = 8'h01;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.wr_en = 1'b0;
        bus.address_valid = 1'b0;
        events_in = 8'h00;
        check("abort rd_data", 32'(bus.rd_data), 0);
        check("abort hit", 32'(bus.hit), 0);
        check("abort irq", 32'(irq), 0);
        check("abort pulse", 32'(pulse_out), 0);
        check("abort ctrl", 32'(ctrl_out[15:0]), 0);
        rd(16'h0042, 16'h1234, 1'b1, "abort scratch");
        rd(16'h005A, 16'h0000, 1'b1, "abort cnt0");
        rd(16'h0044, 16'h0000, 1'b1, "abort sticky");
        rd(16'h0046, 16'h0000, 1'b1, "abort mask");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
